// File: rtl/uart_rx_frame_core_if.sv
// Frame output channel of the UART receiver: received word, error flags and
// a VALID/READY handshake towards the consumer.
interface uart_rx_frame_core_if #(
  parameter int DATA_BITS = 8
);
  logic [DATA_BITS-1:0] DATA;
  logic                 VALID;
  logic                 READY;
  logic                 PAR_ERR;
  logic                 FRM_ERR;
  logic                 BREAK;
  logic                 OVR_ERR;

  modport master (
    output DATA, VALID, PAR_ERR, FRM_ERR, BREAK, OVR_ERR,
    input  READY
  );

  modport slave (
    input  DATA, VALID, PAR_ERR, FRM_ERR, BREAK, OVR_ERR,
    output READY
  );
endinterface

// File: rtl/uart_rx_frame_core.sv
// Oversampling UART receiver with majority-vote bit sampling, runtime parity,
// framing/break/overrun detection and a VALID/READY frame output.
module uart_rx_frame_core #(
  parameter int CLK_HZ    = 50_000_000,
  parameter int BAUD      = 115200,
  parameter int OVS       = 16,
  parameter int DATA_BITS = 8,
  parameter int STOP_BITS = 1
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic                 EN,
  input  logic [1:0]           CHECK,
  input  logic                 RX_pin,
  output logic                 BUSY,
  uart_rx_frame_core_if.master frame
);
  localparam int BAUD_OVS = BAUD * OVS;
  localparam int DIV_RAW  = (CLK_HZ + BAUD_OVS / 2) / BAUD_OVS;
  localparam int DIV      = (DIV_RAW < 1) ? 1 : DIV_RAW;
  localparam int DIV_W    = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int OVS_W    = $clog2(OVS);
  localparam int CNT_W    = 4;

  typedef enum logic [2:0] {
    S_IDLE, S_START, S_DATA, S_PARITY, S_STOP, S_WAIT_HIGH
  } state_t;

  state_t               state_reg, state_next;
  logic                 rx_meta_reg, rx_sync_reg, rx_prev_reg;
  logic [DIV_W-1:0]     div_cnt_reg;
  logic [OVS_W-1:0]     samp_cnt_reg;
  logic [CNT_W-1:0]     bit_cnt_reg;
  logic [1:0]           samp_reg;
  logic [DATA_BITS-1:0] shift_reg;
  logic [1:0]           check_reg;
  logic                 any_one_reg, frm_acc_reg, par_err_acc_reg;

  logic [DATA_BITS-1:0] data_reg;
  logic                 valid_reg, par_err_reg, frm_err_reg, break_reg, ovr_err_reg;

  logic tick, in_frame, decide, bit_end, maj, rx_fall, par_on;
  logic start_det, frame_done, frm_now, brk_now;

  assign tick     = (div_cnt_reg == DIV_W'(DIV - 1));
  assign in_frame = state_reg inside {S_START, S_DATA, S_PARITY, S_STOP};
  assign decide   = in_frame && tick && (samp_cnt_reg == OVS_W'(OVS / 2 + 1));
  assign bit_end  = in_frame && tick && (samp_cnt_reg == OVS_W'(OVS - 1));
  // Third vote is the live synced sample at the decision tick.
  assign maj      = (samp_reg[0] & samp_reg[1]) | (samp_reg[0] & rx_sync_reg) |
                    (samp_reg[1] & rx_sync_reg);
  assign rx_fall  = rx_prev_reg & ~rx_sync_reg;
  assign par_on   = (check_reg == 2'd1) || (check_reg == 2'd2);
  assign frm_now  = frm_acc_reg | ~maj;
  // Break needs every bit up to and including the first stop bit low.
  assign brk_now  = ~any_one_reg & ~((bit_cnt_reg == '0) & maj);

  always_comb begin
    state_next = state_reg;
    start_det  = 1'b0;
    frame_done = 1'b0;
    if (!EN) begin
      state_next = S_IDLE;
    end else begin
      case (state_reg)
        S_IDLE: begin
          if (rx_fall) begin
            state_next = S_START;
            start_det  = 1'b1;
          end
        end
        S_START: begin
          if (decide && maj)
            state_next = S_IDLE;
          else if (bit_end)
            state_next = S_DATA;
        end
        S_DATA: begin
          if (bit_end && (bit_cnt_reg == CNT_W'(DATA_BITS - 1)))
            state_next = par_on ? S_PARITY : S_STOP;
        end
        S_PARITY: begin
          if (bit_end)
            state_next = S_STOP;
        end
        S_STOP: begin
          if (decide && (bit_cnt_reg == CNT_W'(STOP_BITS - 1))) begin
            frame_done = 1'b1;
            state_next = brk_now ? S_WAIT_HIGH : S_IDLE;
          end
        end
        S_WAIT_HIGH: begin
          if (rx_sync_reg)
            state_next = S_IDLE;
        end
        default: state_next = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_reg       <= S_IDLE;
      rx_meta_reg     <= 1'b1;
      rx_sync_reg     <= 1'b1;
      rx_prev_reg     <= 1'b1;
      div_cnt_reg     <= '0;
      samp_cnt_reg    <= '0;
      bit_cnt_reg     <= '0;
      samp_reg        <= '0;
      shift_reg       <= '0;
      check_reg       <= '0;
      any_one_reg     <= 1'b0;
      frm_acc_reg     <= 1'b0;
      par_err_acc_reg <= 1'b0;
    end else begin
      state_reg   <= state_next;
      rx_meta_reg <= RX_pin;
      rx_sync_reg <= rx_meta_reg;
      rx_prev_reg <= rx_sync_reg;

      if (start_det || tick)
        div_cnt_reg <= '0;
      else
        div_cnt_reg <= div_cnt_reg + DIV_W'(1);

      if (start_det) begin
        samp_cnt_reg    <= '0;
        check_reg       <= CHECK;
        any_one_reg     <= 1'b0;
        frm_acc_reg     <= 1'b0;
        par_err_acc_reg <= 1'b0;
      end else if (in_frame && tick) begin
        samp_cnt_reg <= (samp_cnt_reg == OVS_W'(OVS - 1)) ? '0 : samp_cnt_reg + OVS_W'(1);
        if (samp_cnt_reg == OVS_W'(OVS / 2 - 1))
          samp_reg[0] <= rx_sync_reg;
        if (samp_cnt_reg == OVS_W'(OVS / 2))
          samp_reg[1] <= rx_sync_reg;
      end

      if (state_next != state_reg)
        bit_cnt_reg <= '0;
      else if (bit_end)
        bit_cnt_reg <= bit_cnt_reg + CNT_W'(1);

      if (decide) begin
        case (state_reg)
          S_DATA: begin
            shift_reg   <= {maj, shift_reg[DATA_BITS-1:1]};
            any_one_reg <= any_one_reg | maj;
          end
          S_PARITY: begin
            par_err_acc_reg <= (^shift_reg) ^ maj ^ (check_reg == 2'd1);
            any_one_reg     <= any_one_reg | maj;
          end
          S_STOP: begin
            frm_acc_reg <= frm_now;
            if (bit_cnt_reg == '0)
              any_one_reg <= any_one_reg | maj;
          end
          default: ;
        endcase
      end
    end
  end

  // A frame finishing while the previous one is still unaccepted is dropped.
  always_ff @(posedge CLK) begin
    if (RST) begin
      data_reg    <= '0;
      valid_reg   <= 1'b0;
      par_err_reg <= 1'b0;
      frm_err_reg <= 1'b0;
      break_reg   <= 1'b0;
      ovr_err_reg <= 1'b0;
    end else if (frame_done) begin
      if (!valid_reg || frame.READY) begin
        data_reg    <= shift_reg;
        valid_reg   <= 1'b1;
        par_err_reg <= par_err_acc_reg;
        frm_err_reg <= frm_now;
        break_reg   <= brk_now;
        ovr_err_reg <= 1'b0;
      end else begin
        ovr_err_reg <= 1'b1;
      end
    end else if (valid_reg && frame.READY) begin
      valid_reg   <= 1'b0;
      par_err_reg <= 1'b0;
      frm_err_reg <= 1'b0;
      break_reg   <= 1'b0;
      ovr_err_reg <= 1'b0;
    end
  end

  assign BUSY          = (state_reg != S_IDLE);
  assign frame.DATA    = data_reg;
  assign frame.VALID   = valid_reg;
  assign frame.PAR_ERR = par_err_reg;
  assign frame.FRM_ERR = frm_err_reg;
  assign frame.BREAK   = break_reg;
  assign frame.OVR_ERR = ovr_err_reg;
endmodule

// File: tb/tb_uart_rx_frame_core.sv
// Directed bench for uart_rx_frame_core: serial frames are driven bit by bit and
// a frame-level model predicts the output channel, checked every settled cycle.
module tb_uart_rx_frame_core;
  localparam int CLK_HZ    = 50_000_000;
  localparam int BAUD      = 3_125_000;
  localparam int OVS       = 16;
  localparam int DATA_BITS = 8;
  localparam int STOP_BITS = 1;
  localparam int BIT_CLKS  = 16;

  typedef struct packed {
    logic [7:0] data;
    logic       par;
    logic       frm;
    logic       brk;
    logic       ovr;
  } word_t;

  logic       CLK = 1'b0;
  logic       RST;
  logic       EN;
  logic [1:0] CHECK;
  logic       RX_pin;
  logic       BUSY;

  uart_rx_frame_core_if #(.DATA_BITS(DATA_BITS)) rx_if ();

  uart_rx_frame_core #(
    .CLK_HZ(CLK_HZ), .BAUD(BAUD), .OVS(OVS),
    .DATA_BITS(DATA_BITS), .STOP_BITS(STOP_BITS)
  ) dut (
    .CLK(CLK), .RST(RST), .EN(EN), .CHECK(CHECK),
    .RX_pin(RX_pin), .BUSY(BUSY), .frame(rx_if)
  );

  always #10 CLK = ~CLK;

  int    checks = 0;
  int    errors = 0;
  int    hs_cnt = 0;
  logic  check_en = 1'b0;
  logic  exp_valid = 1'b0;
  word_t exp_word = '0;
  word_t last_got = '0;
  word_t acc_q[$];
  word_t got_q[$];

  task automatic check1(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  // Expected word of a frame from the line bits actually sent.
  function automatic word_t frame_word(input logic [7:0] d, input logic [1:0] chk,
                                       input logic pbit, input logic sbit);
    word_t w;
    int    ones;
    bit    p_on;
    p_on   = (chk == 2'd1) || (chk == 2'd2);
    ones   = $countones(d) + int'(pbit);
    w.data = d;
    w.par  = p_on && ((chk == 2'd1) ? (ones % 2 == 0) : (ones % 2 == 1));
    w.frm  = !sbit;
    w.brk  = (d == 8'h00) && !(p_on && pbit) && !sbit;
    w.ovr  = 1'b0;
    return w;
  endfunction

  task automatic model_accept();
    if (exp_valid) begin
      acc_q.push_back(exp_word);
      exp_valid = 1'b0;
      exp_word  = '0;
    end
  endtask

  task automatic model_arrive(input word_t w);
    if (exp_valid && !rx_if.READY) begin
      exp_word.ovr = 1'b1;
    end else begin
      exp_word  = w;
      exp_valid = 1'b1;
      if (rx_if.READY) model_accept();
    end
  endtask

  task automatic drive_bit(input logic b, input int ncl);
    RX_pin = b;
    repeat (ncl) @(negedge CLK);
  endtask

  task automatic send_frame(input logic [7:0] d, input logic pbit, input logic sbit, input int gap);
    check_en = 1'b0;
    @(negedge CLK);
    drive_bit(1'b0, BIT_CLKS);
    for (int i = 0; i < 8; i++) drive_bit(d[i], BIT_CLKS);
    if (CHECK == 2'd1 || CHECK == 2'd2) drive_bit(pbit, BIT_CLKS);
    drive_bit(sbit, BIT_CLKS);
    RX_pin = 1'b1;
    repeat (gap) @(negedge CLK);
    model_arrive(frame_word(d, CHECK, pbit, sbit));
    $display("frame %02h chk=%0d p=%0b s=%0b sent, hs=%0d", d, CHECK, pbit, sbit, hs_cnt);
    if (gap >= 4) check_en = 1'b1;
  endtask

  task automatic pulse_ready();
    @(negedge CLK);
    rx_if.READY = 1'b1;
    model_accept();
    @(negedge CLK);
    rx_if.READY = 1'b0;
  endtask

  // Handshake monitor: samples just before the edge that completes it.
  initial begin
    word_t w;
    forever begin
      @(negedge CLK);
      #5;
      if (rx_if.VALID && rx_if.READY && !RST) begin
        w = {rx_if.DATA, rx_if.PAR_ERR, rx_if.FRM_ERR, rx_if.BREAK, rx_if.OVR_ERR};
        got_q.push_back(w);
        last_got = w;
        hs_cnt++;
      end
    end
  end

  // Compare process: output state against the model whenever the line is settled,
  // and every delivered word against the model's accepted words.
  initial begin
    word_t g_w, e_w;
    logic [13:0] got_v, exp_v;
    forever begin
      @(posedge CLK);
      #2;
      if (check_en) begin
        got_v = {rx_if.VALID, rx_if.PAR_ERR, rx_if.FRM_ERR, rx_if.BREAK, rx_if.OVR_ERR,
                 BUSY, rx_if.VALID ? rx_if.DATA : 8'h00};
        exp_v = {exp_valid, exp_word.par, exp_word.frm, exp_word.brk, exp_word.ovr,
                 1'b0, exp_valid ? exp_word.data : 8'h00};
        check1("outputs", 32'(got_v), 32'(exp_v));
      end
      while (got_q.size() > 0 && acc_q.size() > 0) begin
        g_w = got_q.pop_front();
        e_w = acc_q.pop_front();
        check1("handshake_word", 32'(g_w), 32'(e_w));
      end
    end
  end

  initial begin
    logic seen;
    logic fell;
    int   hs_before;
    RST = 1'b1; EN = 1'b1; CHECK = 2'd0; RX_pin = 1'b1; rx_if.READY = 1'b0;
    repeat (3) @(negedge CLK);
    check1("reset_outputs",
           32'({rx_if.VALID, rx_if.PAR_ERR, rx_if.FRM_ERR, rx_if.BREAK, rx_if.OVR_ERR, BUSY, rx_if.DATA}),
           32'd0);
    RST = 1'b0;
    repeat (3) @(negedge CLK);
    check_en = 1'b1;

    // 1: plain 8N1 frame with the consumer always ready
    rx_if.READY = 1'b1;
    send_frame(8'hA5, 1'b0, 1'b1, 4);
    check1("t1_word", 32'(last_got), 32'h0A50);
    check1("t1_single_valid", hs_cnt, 1);

    // 2: even parity, wrong then correct parity bit
    CHECK = 2'd2;
    send_frame(8'h07, 1'b0, 1'b1, 4);
    check1("t2_par_err_bad", 32'(last_got.par), 1);
    send_frame(8'h07, 1'b1, 1'b1, 4);
    check1("t2_par_err_good", 32'(last_got.par), 0);
    check1("t2_data", 32'(last_got.data), 32'h07);
    CHECK = 2'd0;

    // 3: short low glitch is a false start
    check_en = 1'b0;
    hs_before = hs_cnt;
    seen = 1'b0; fell = 1'b0;
    @(negedge CLK);
    RX_pin = 1'b0;
    for (int i = 0; i < 40 && !fell; i++) begin
      @(negedge CLK);
      if (i == 3) RX_pin = 1'b1;
      if (BUSY) seen = 1'b1;
      else if (seen) fell = 1'b1;
    end
    check1("t3_busy_rise", 32'(seen), 1);
    check1("t3_busy_fall", 32'(fell), 1);
    check1("t3_no_valid", hs_cnt, hs_before);
    repeat (4) @(negedge CLK);
    check_en = 1'b1;

    // EN dropped after the start bit: frame discarded
    check_en = 1'b0;
    @(negedge CLK);
    drive_bit(1'b0, BIT_CLKS);
    EN = 1'b0;
    for (int i = 0; i < 8; i++) drive_bit(i < 4, BIT_CLKS);
    drive_bit(1'b1, BIT_CLKS);
    repeat (4) @(negedge CLK);
    check1("en_abort_busy", 32'(BUSY), 0);
    EN = 1'b1;
    check_en = 1'b1;

    // 4: framing error, then a break, then recovery
    send_frame(8'h3C, 1'b0, 1'b0, 4);
    check1("t4_frm_word", 32'(last_got), 32'h3C4);
    check_en = 1'b0;
    hs_before = hs_cnt;
    @(negedge CLK);
    drive_bit(1'b0, 30 * BIT_CLKS);
    RX_pin = 1'b1;
    repeat (8) @(negedge CLK);
    model_arrive(frame_word(8'h00, CHECK, 1'b0, 1'b0));
    check1("t4_break_word", 32'(last_got), 32'h006);
    check1("t4_break_once", hs_cnt - hs_before, 1);
    check_en = 1'b1;
    send_frame(8'hC3, 1'b0, 1'b1, 4);
    check1("t4_after_break", 32'(last_got), 32'hC30);

    // 5: overrun while the consumer stalls
    rx_if.READY = 1'b0;
    send_frame(8'h11, 1'b0, 1'b1, 0);
    send_frame(8'h22, 1'b0, 1'b1, 4);
    check1("t5_data", 32'(rx_if.DATA), 32'h11);
    check1("t5_ovr", 32'(rx_if.OVR_ERR), 1);
    check1("t5_valid", 32'(rx_if.VALID), 1);
    pulse_ready();
    check1("t5_valid_clr", 32'(rx_if.VALID), 0);
    check1("t5_ovr_clr", 32'(rx_if.OVR_ERR), 0);

    // 6: reset in the middle of the data bits
    send_frame(8'h33, 1'b0, 1'b1, 4);
    check_en = 1'b0;
    @(negedge CLK);
    drive_bit(1'b0, BIT_CLKS);
    drive_bit(1'b0, BIT_CLKS);
    drive_bit(1'b1, BIT_CLKS);
    drive_bit(1'b0, BIT_CLKS / 2);
    RST = 1'b1;
    RX_pin = 1'b1;
    @(negedge CLK);
    RST = 1'b0;
    exp_valid = 1'b0;
    exp_word  = '0;
    check1("t6_reset_outputs",
           32'({rx_if.VALID, rx_if.PAR_ERR, rx_if.FRM_ERR, rx_if.BREAK, rx_if.OVR_ERR, BUSY, rx_if.DATA}),
           32'd0);
    repeat (4) @(negedge CLK);
    check_en = 1'b1;
    rx_if.READY = 1'b1;
    send_frame(8'h5A, 1'b0, 1'b1, 4);
    check1("t6_word", 32'(last_got), 32'h5A0);

    repeat (10) @(negedge CLK);
    check1("unmatched_dut_words", got_q.size(), 0);
    check1("unmatched_model_words", acc_q.size(), 0);
    check1("handshake_count", hs_cnt, 8);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
